// File: rtl/density_phase_sequencer.sv
// Phase sequencer for the density-based traffic light controller.
// Serves four lanes round-robin, skips empty lanes, sizes each green from the
// served lane's density, and inserts yellow and all-red intervals between phases.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - asynchronous active-low reset
//   DENS  - lane densities, lane k on bits [2k+1:2k] (00 empty .. 11 high)
//   SEL   - served lane, to the demux SEL (registered)
//   I     - served lane green, to the demux I (registered)
//   YEL   - served lane yellow (registered)
module density_phase_sequencer #(
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned GREEN_LOW  = 5,
    parameter int unsigned GREEN_MED  = 10,
    parameter int unsigned GREEN_HIGH = 20,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DENS,
    output logic [1:0] SEL,
    output logic       I,
    output logic       YEL
);

    localparam int unsigned PW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALL_RED = 2'd1,
        GREEN   = 2'd2,
        YELLOW  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [1:0]      last;
    logic [1:0]      last_n;
    logic [1:0]      sel_n;
    logic            i_n;
    logic            yel_n;
    logic [CW-1:0]   elapsed;
    logic [CW-1:0]   elapsed_n;
    logic [CW-1:0]   elapsed_inc;
    logic [CW-1:0]   target;
    logic [CW-1:0]   target_n;
    logic            cand_found;
    logic [1:0]      cand;
    logic [1:0]      scan_lane;
    logic [1:0]      sel_dens;

    // Free-running tick prescaler, never restarted by state changes
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Round-robin search: last+1, last+2, last+3, then last itself
    always_comb begin
        cand_found = 1'b0;
        cand       = last;
        scan_lane  = last;
        for (int k = 1; k <= 4; k++) begin
            scan_lane = last + 2'(k);
            if (!cand_found && (DENS[{scan_lane, 1'b0} +: 2] != 2'b00)) begin
                cand_found = 1'b1;
                cand       = scan_lane;
            end
        end
    end

    assign sel_dens    = DENS[{SEL, 1'b0} +: 2];
    assign elapsed_inc = elapsed + CW'(1);

    // Green length from density; an empty lane still gets the minimum green
    function automatic logic [CW-1:0] green_len(input logic [1:0] d);
        case (d)
            2'b10:   green_len = CW'(GREEN_MED);
            2'b11:   green_len = CW'(GREEN_HIGH);
            default: green_len = CW'(GREEN_LOW);
        endcase
    endfunction

    // Next-state and registered-output logic. SEL only moves on transitions
    // into ALL_RED, where I is already 0, so the demux never sees SEL and I move together.
    always_comb begin
        state_n   = state;
        sel_n     = SEL;
        i_n       = I;
        yel_n     = YEL;
        last_n    = last;
        elapsed_n = elapsed;
        target_n  = target;
        unique case (state)
            IDLE: begin
                i_n   = 1'b0;
                yel_n = 1'b0;
                if (cand_found) begin
                    sel_n     = cand;
                    state_n   = ALL_RED;
                    elapsed_n = '0;
                end
            end
            ALL_RED: begin
                if (tick) begin
                    if (elapsed_inc >= CW'(ALLRED_T)) begin
                        state_n   = GREEN;
                        i_n       = 1'b1;
                        last_n    = SEL;
                        target_n  = green_len(sel_dens);
                        elapsed_n = '0;
                    end else begin
                        elapsed_n = elapsed_inc;
                    end
                end
            end
            GREEN: begin
                if (tick) begin
                    if ((elapsed_inc >= target) ||
                        ((sel_dens == 2'b00) && (elapsed_inc >= CW'(GREEN_LOW)))) begin
                        state_n   = YELLOW;
                        i_n       = 1'b0;
                        yel_n     = 1'b1;
                        elapsed_n = '0;
                    end else begin
                        elapsed_n = elapsed_inc;
                    end
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (elapsed_inc >= CW'(YELLOW_T)) begin
                        yel_n     = 1'b0;
                        elapsed_n = '0;
                        if (cand_found) begin
                            sel_n   = cand;
                            state_n = ALL_RED;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        elapsed_n = elapsed_inc;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                i_n     = 1'b0;
                yel_n   = 1'b0;
            end
        endcase
    end

    // State and output registers; last resets to 3 so the first search starts at lane 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            SEL     <= 2'b00;
            I       <= 1'b0;
            YEL     <= 1'b0;
            last    <= 2'b11;
            elapsed <= '0;
            target  <= '0;
        end else begin
            state   <= state_n;
            SEL     <= sel_n;
            I       <= i_n;
            YEL     <= yel_n;
            last    <= last_n;
            elapsed <= elapsed_n;
            target  <= target_n;
        end
    end

endmodule

// File: tb/tb_density_phase_sequencer.sv
// Self-checking bench for density_phase_sequencer: a phase-level reference
// model checked every cycle, a green-run recorder, and directed scenarios.
module tb_density_phase_sequencer;

    localparam int unsigned TD = 1;
    localparam int unsigned GL = 2;
    localparam int unsigned GM = 4;
    localparam int unsigned GH = 6;
    localparam int unsigned YT = 2;
    localparam int unsigned AR = 1;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [7:0] DENS;
    logic [1:0] SEL;
    logic       I;
    logic       YEL;

    density_phase_sequencer #(
        .TICK_DIV  (TD),
        .GREEN_LOW (GL),
        .GREEN_MED (GM),
        .GREEN_HIGH(GH),
        .YELLOW_T  (YT),
        .ALLRED_T  (AR)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .DENS (DENS),
        .SEL  (SEL),
        .I    (I),
        .YEL  (YEL)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase + cycles remaining) ----------------
    // phase: 0 idle, 1 all-red, 2 green, 3 yellow
    int         m_phase;
    logic [1:0] m_sel;
    logic [1:0] m_last;
    int         m_left;
    int         m_len;
    int         m_done;

    function automatic int field(input logic [7:0] d, input int lane);
        return int'((d >> (2 * lane)) & 8'd3);
    endfunction

    function automatic int scan(input logic [1:0] from, input logic [7:0] d);
        for (int k = 1; k <= 4; k++) begin
            if (field(d, (int'(from) + k) % 4) != 0) return (int'(from) + k) % 4;
        end
        return -1;
    endfunction

    function automatic int len_of(input int dv);
        case (dv)
            3:       return GH;
            2:       return GM;
            default: return GL;
        endcase
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= 0;
            m_sel   <= 2'd0;
            m_last  <= 2'd3;
            m_left  <= 0;
            m_done  <= 0;
        end else begin
            case (m_phase)
                0: if (scan(m_last, DENS) >= 0) begin
                    m_sel   <= 2'(scan(m_last, DENS));
                    m_phase <= 1;
                    m_left  <= AR;
                end
                1: if (m_left <= 1) begin
                    m_phase <= 2;
                    m_last  <= m_sel;
                    m_len   <= len_of(field(DENS, int'(m_sel)));
                    m_done  <= 0;
                end else begin
                    m_left <= m_left - 1;
                end
                2: if ((m_done + 1 >= m_len) ||
                       (field(DENS, int'(m_sel)) == 0 && m_done + 1 >= GL)) begin
                    m_phase <= 3;
                    m_left  <= YT;
                end else begin
                    m_done <= m_done + 1;
                end
                default: if (m_left <= 1) begin
                    if (scan(m_last, DENS) >= 0) begin
                        m_sel   <= 2'(scan(m_last, DENS));
                        m_phase <= 1;
                        m_left  <= AR;
                    end else begin
                        m_phase <= 0;
                    end
                end else begin
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    // ---------------- compare process + green-run recorder ----------------
    int         rst_count = 0;
    int         p_rst_count = 0;
    logic [1:0] p_sel = 2'd0;
    logic       p_i = 1'b0;
    int         run_len = 0;
    logic [1:0] run_sel = 2'd0;
    int         run_sel_q[$];
    int         run_len_q[$];

    always @(negedge RST_N) rst_count <= rst_count + 1;

    always @(negedge CLK) begin
        check("sel_vs_model", int'(SEL), int'(m_sel));
        check("i_vs_model", int'(I), int'(m_phase == 2));
        check("yel_vs_model", int'(YEL), int'(m_phase == 3));
        check("i_yel_exclusive", int'(I && YEL), 0);
        if (RST_N && rst_count == p_rst_count)
            check("sel_moved_near_green", int'((SEL != p_sel) && (I || p_i)), 0);
        p_sel       <= SEL;
        p_i         <= I;
        p_rst_count <= rst_count;
        if (I) begin
            run_len <= run_len + 1;
            run_sel <= SEL;
        end else if (run_len > 0) begin
            run_sel_q.push_back(int'(run_sel));
            run_len_q.push_back(run_len);
            run_len <= 0;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_run(input string name, input int idx, input int s, input int l);
        if (idx < run_len_q.size()) begin
            check({name, "_lane"}, run_sel_q[idx], s);
            check({name, "_len"}, run_len_q[idx], l);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: green run %0d missing, only %0d recorded", name, idx, run_len_q.size());
        end
    endtask

    task automatic wait_green(input int want_sel, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (I && (want_sel < 0 || int'(SEL) == want_sel)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_green: no green on lane %0d within 60 cycles", want_sel);
        end
    endtask

    int base;
    bit ok;

    initial begin
        RST_N = 1'b1;
        DENS  = 8'h00;
        #1 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;

        // Empty road: stays idle
        repeat (22) @(negedge CLK);
        check("idle_sel", int'(SEL), 0);
        check("idle_i", int'(I), 0);
        check("idle_yel", int'(YEL), 0);

        // Lane 0 high only: repeated 6-cycle greens on lane 0
        base = run_len_q.size();
        DENS = 8'b0000_0011;
        repeat (30) @(negedge CLK);
        check_run("l0_run0", base + 0, 0, 6);
        check_run("l0_run1", base + 1, 0, 6);
        check_run("l0_run2", base + 2, 0, 6);
        DENS = 8'h00;
        repeat (20) @(negedge CLK);

        // Lanes 1/2/3 = med/low/high: order 1,2,3,1 with greens 4,2,6,4
        base = run_len_q.size();
        DENS = 8'b11_01_10_00;
        repeat (34) @(negedge CLK);
        DENS = 8'h00;
        repeat (20) @(negedge CLK);
        check_run("rr_run0", base + 0, 1, 4);
        check_run("rr_run1", base + 1, 2, 2);
        check_run("rr_run2", base + 2, 3, 6);
        check_run("rr_run3", base + 3, 1, 4);

        // Early exit on lane 1: drop during 3rd green cycle, then during 1st
        base = run_len_q.size();
        DENS = 8'b0000_1100;
        wait_green(1, ok);
        repeat (2) @(negedge CLK);
        DENS = 8'h00;
        repeat (12) @(negedge CLK);
        DENS = 8'b0000_1100;
        wait_green(1, ok);
        DENS = 8'h00;
        repeat (12) @(negedge CLK);
        check_run("early3", base + 0, 1, 3);
        check_run("early1", base + 1, 1, 2);

        // Random traffic, model and safety checks every cycle
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) DENS = 8'($urandom) & 8'($urandom);
            @(negedge CLK);
        end

        // Reset during lane 2 green, then restart on lane 2
        DENS = 8'b0011_0000;
        wait_green(2, ok);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_sel", int'(SEL), 0);
        check("async_rst_i", int'(I), 0);
        check("async_rst_yel", int'(YEL), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("post_rst_allred_sel", int'(SEL), 2);
        check("post_rst_allred_i", int'(I), 0);
        @(negedge CLK);
        check("post_rst_green_sel", int'(SEL), 2);
        check("post_rst_green_i", int'(I), 1);
        repeat (5) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/density_phase_sequencer.md
# density_phase_sequencer

Phase sequencer for the density-based traffic light controller. It sits directly upstream of the active-low lane demultiplexer and drives that block's `I` (green enable) and `SEL` (lane select) inputs. It serves the four lanes in round-robin order, skips lanes with no traffic, and sizes each green phase from the served lane's density level. Yellow and all-red intervals are inserted between phases.

## Interface
- `TICK_DIV`, default 1: clock cycles per timing tick (1..65535); all durations below count ticks.
- `GREEN_LOW`, default 5: green length for density 01; also the minimum green before early exit.
- `GREEN_MED`, default 10: green length for density 10.
- `GREEN_HIGH`, default 20: green length for density 11.
- `YELLOW_T`, default 3: yellow length.
- `ALLRED_T`, default 1: all-red length.
- All durations are in the range 1..255 and must satisfy GREEN_LOW ≤ GREEN_MED ≤ GREEN_HIGH.

Ports:
- `CLK` input, 1 bit: the only clock; rising edge.
- `RST_N` input, 1 bit: reset, asynchronous and active-low.
- `DENS` input, 8 bits: lane density levels; lane k uses bits [2k+1:2k]. Encoding: 00 empty, 01 low, 10 medium, 11 high. Synchronous to `CLK`.
- `SEL` output, 2 bits: served lane, to the demux `SEL`. Registered.
- `I` output, 1 bit: 1 = served lane green, to the demux `I`. Registered.
- `YEL` output, 1 bit: 1 = served lane yellow. Registered.

## Operation
- FSM states: IDLE, ALL_RED, GREEN, YELLOW.
- Internal state: `last` lane pointer (2 bits), tick prescaler, 8-bit elapsed counter, 8-bit target register.
- Round-robin search: scan lanes `last+1`, `last+2`, `last+3`, `last` (mod 4). Pick the first lane with a nonzero `DENS` field. If all four fields are 00, there is no candidate.
- IDLE: `I`=0, `YEL`=0. Evaluate every cycle, with no tick required. On a candidate: `SEL`←candidate, go to ALL_RED, clear elapsed.
- ALL_RED: `I`=0, `YEL`=0. After ALLRED_T ticks, go to GREEN and:
  - `I`←1;
  - `last`←`SEL`;
  - load target from `DENS[SEL]` (01→GREEN_LOW, 10→GREEN_MED, 11→GREEN_HIGH, 00→GREEN_LOW);
  - clear elapsed.
- GREEN: `I`=1. Elapsed increments on each tick. Go to YELLOW (`I`←0, `YEL`←1) when either:
  - elapsed reaches target; or
  - early exit: `DENS[SEL]`==00 on a tick and elapsed (after increment) ≥ GREEN_LOW.
- YELLOW: `I`=0, `YEL`=1. After YELLOW_T ticks, `YEL`←0 and run the round-robin search from `last`:
  - candidate found: `SEL`←candidate, go to ALL_RED. A candidate equal to `last` (only that lane busy) is allowed, and `SEL` is then unchanged.
  - no candidate: go to IDLE with `SEL` unchanged.
- Demux safety rule (hard requirement): `SEL` and `I` never change on the same edge, and `SEL` changes only while `I`=0.
  - The downstream demux latches per-lane values, so the old lane must have seen `I`=0 before `SEL` moves.
  - Guaranteed by the FSM: `I` falls on entry to YELLOW, and `SEL` moves only on YELLOW→ALL_RED or IDLE→ALL_RED.
- `DENS` changes mid-phase do not alter the loaded target; they act only through early exit.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, `SEL`=00, `I`=0, `YEL`=0;
  - `last`=11, so the first search starts at lane 0;
  - prescaler, elapsed and target all 0.
- Tick: prescaler counts 0..TICK_DIV-1 and `tick`=1 on the cycle where it equals TICK_DIV-1. It free-runs from reset and is never restarted by state changes.
- With TICK_DIV=1, every cycle is a tick:
  - ALL_RED lasts exactly ALLRED_T cycles;
  - GREEN lasts exactly target cycles (`I`=1);
  - YELLOW lasts exactly YELLOW_T cycles.
- IDLE→ALL_RED: `SEL` is updated on the first edge at which `DENS` is nonzero. Latency is 1 cycle.
- Reset asserted mid-phase: outputs go to reset values immediately, without a clock edge. `I` may drop while `SEL` holds, which is acceptable.

## Test plan
Bench parameters for every case: TICK_DIV=1, GREEN_LOW=2, GREEN_MED=4, GREEN_HIGH=6, YELLOW_T=2, ALLRED_T=1.
- Reset with `DENS`=00000000 held → `SEL`=00, `I`=0, `YEL`=0 for at least 20 cycles; state remains IDLE.
- `DENS`=00000011 (lane 0 high) → `SEL`=0; 1 cycle all-red; `I`=1 for 6 cycles; `YEL`=1 for 2 cycles; 1 all-red; repeat on lane 0 with `SEL` never changing.
- `DENS`=11011000 (lane 0 empty, lanes 1/2/3 = 10/01/11) → lane order 1,2,3,1; green lengths 4,2,6,4.
- Lane 1 at 11; drop `DENS[3:2]` to 00 after 3 green cycles → `I` falls after the 3rd cycle (early exit, elapsed 3 ≥ 2). With the drop after 1 cycle instead, `I` falls after the 2nd cycle.
- Checker on every cycle, with random `DENS` over 10k cycles:
  - `SEL` never changes on a cycle where `I` is 1 before or after the edge;
  - `I` and `YEL` are never both 1.
- Assert `RST_N` during GREEN of lane 2 → `I`=0, `SEL`=00 asynchronously; after release with `DENS`=00110000, the next green is on lane 2 after 1 all-red cycle.
